// File: rtl/cordic_pkg.sv
// Shared constants, result-pair type and gain-compensation helper for the
// CORDIC output stage.
//
// Contents:
//   K_Q15      - CORDIC gain 0.60725 in Q15.
//   ROUND_Q15  - Q15 half-LSB. Adding it before the shift rounds half up.
//   res_pair_t - {x, y} result pair at full internal precision.
//   gain_comp  - (c * K_Q15 + ROUND_Q15) >>> 15 at full precision.
package cordic_pkg;

    localparam int K_Q15     = 19898;
    localparam int ROUND_Q15 = 16384;
    localparam int Q15_SHIFT = 15;
    localparam int PAIR_W    = 32;

    typedef struct packed {
        logic signed [PAIR_W-1:0] x;
        logic signed [PAIR_W-1:0] y;
    } res_pair_t;

    // The product is formed at 64 bits so that no intermediate overflows.
    // The caller truncates the returned value to the result width.
    function automatic logic signed [PAIR_W-1:0] gain_comp(input logic signed [PAIR_W-1:0] c);
        return PAIR_W'((64'(c) * 64'(K_Q15) + 64'(ROUND_Q15)) >>> Q15_SHIFT);
    endfunction

endpackage

// File: rtl/cordic_res_fifo.sv
// Show-ahead result FIFO. The head entry is visible on rd_data whenever
// rd_valid is high. A push while full is dropped, unless a pop happens in
// the same cycle.
//
// Parameters: WIDTH - entry width; DEPTH - entries, a power of two >= 2.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   push, push_data     - write request and data
//   full                - FIFO holds DEPTH entries
//   rd_valid, rd_ready  - read handshake; pop on rd_valid & rd_ready
//   rd_data             - head entry
//   count               - occupancy, 0..DEPTH
module cordic_res_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign rd_valid = (count != '0);
    assign do_pop   = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot that a full FIFO needs.
    assign do_push  = push & (~full | do_pop);
    assign rd_data  = mem[rd_ptr_q];

    // Storage is not reset. Only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_out_stage.sv
// Output stage for a pipelined CORDIC. It tracks which cycles carry valid
// results, applies optional gain compensation, and buffers the results in a
// show-ahead FIFO with a valid/ready output and a sticky overflow flag.
//
// Build option: define CORDIC_GAIN_COMP_EN to scale results by K (Q15, round
// half up). When it is undefined, results pass through unscaled with the same
// latency.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   in_valid         - a sample enters the upstream CORDIC this cycle
//   cx, cy           - CORDIC Xout/Yout (signed, BIT_WIDTH+1)
//   x_out, y_out     - FIFO head result; zero when out_valid is low
//   out_valid        - head is valid
//   out_ready        - downstream accepts the head
//   fifo_count       - FIFO occupancy
//   overflow         - sticky: a result was dropped because the FIFO was full
//   ovf_clr          - clears overflow; a same-cycle drop takes priority
module cordic_out_stage
    import cordic_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned ITERATIONS = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [BIT_WIDTH:0]     cx,
    input  logic signed [BIT_WIDTH:0]     cy,
    output logic signed [BIT_WIDTH:0]     x_out,
    output logic signed [BIT_WIDTH:0]     y_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int unsigned RES_W = BIT_WIDTH + 1;

    logic [ITERATIONS-1:0]   vld_sr_q;
    logic                    tap;
    logic signed [RES_W-1:0] comp_x_d, comp_y_d;
    logic signed [RES_W-1:0] comp_x_q, comp_y_q;
    logic                    comp_vld_q;
    logic                    fifo_full, fifo_rd_valid, pop, drop;
    logic [2*RES_W-1:0]      fifo_rd_data;

    // When the MSB of vld_sr_q is set, cx/cy hold the result of the sample
    // that entered ITERATIONS cycles earlier.
    assign tap = vld_sr_q[ITERATIONS-1];

`ifdef CORDIC_GAIN_COMP_EN
    // K < 1, so the scaled value always fits the result width.
    assign comp_x_d = RES_W'(gain_comp(PAIR_W'(cx)));
    assign comp_y_d = RES_W'(gain_comp(PAIR_W'(cy)));
`else
    assign comp_x_d = cx;
    assign comp_y_d = cy;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_q   <= '0;
            comp_vld_q <= 1'b0;
            comp_x_q   <= '0;
            comp_y_q   <= '0;
        end else begin
            // Shift in_valid in at the LSB. The old MSB is dropped here
            // because it has already been used as tap.
            vld_sr_q   <= ITERATIONS'({vld_sr_q, in_valid});
            comp_vld_q <= tap;
            if (tap) begin
                comp_x_q <= comp_x_d;
                comp_y_q <= comp_y_d;
            end
        end
    end

    assign out_valid = fifo_rd_valid & ~rst;
    assign pop       = out_valid & out_ready;
    assign drop      = comp_vld_q & fifo_full & ~pop;
    assign x_out     = out_valid ? fifo_rd_data[2*RES_W-1:RES_W] : '0;
    assign y_out     = out_valid ? fifo_rd_data[RES_W-1:0] : '0;

    cordic_res_fifo #(
        .WIDTH (2 * RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (comp_vld_q),
        .push_data ({comp_x_q, comp_y_q}),
        .full      (fifo_full),
        .rd_valid  (fifo_rd_valid),
        .rd_ready  (out_ready),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count)
    );

    // Set wins over clear, so a drop is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cordic_out_stage.sv
// Self-checking bench for cordic_out_stage (BIT_WIDTH=8, ITERATIONS=8,
// FIFO_DEPTH=4). A queue-based reference model predicts the FIFO contents
// from the sample history. Directed scenarios are followed by randomized
// traffic.
module tb_cordic_out_stage;
    import cordic_pkg::*;

    localparam int BW    = 8;
    localparam int IT    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXS  = 4096;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXP_X = 121;
    localparam int EXP_Y = -121;
`else
    localparam int EXP_X = 200;
    localparam int EXP_Y = -200;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, ovf_clr, out_valid, overflow;
    logic signed [BW:0] cx, cy, x_out, y_out;
    logic [CW-1:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cordic_out_stage #(
        .BIT_WIDTH  (BW),
        .ITERATIONS (IT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .cx         (cx),
        .cy         (cy),
        .x_out      (x_out),
        .y_out      (y_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    // Reference model state
    res_pair_t mq[$];
    bit        m_ovf = 1'b0;
    int        k = 0;
    int        last_rst = -1;
    bit        vh[MAXS];
    int        cxh[MAXS];
    int        cyh[MAXS];

    function automatic int rnd();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    // Expected result for CORDIC output c, from plain integer arithmetic with
    // floor division.
    function automatic int scale(input int c);
`ifdef CORDIC_GAIN_COMP_EN
        int n;
        int q;
        n = c * 19898 + 16384;
        q = n / 32768;
        if (n < 0 && q * 32768 != n) q = q - 1;
        return q;
`else
        return c;
`endif
    endfunction

    // Applies one cycle of inputs and advances the model over the next edge,
    // then returns at the following negedge.
    task automatic cyc(input bit iv, input int x, input int y, input bit rdy,
                       input bit clr, input bit r);
        bit        pop;
        bit        push;
        bit        drop;
        res_pair_t e;
        if (k >= MAXS) begin
            $display("FAIL step_budget: got %0d steps, limit %0d", k, MAXS);
            $fatal(1);
        end
        rst       = r;
        in_valid  = iv && !r;
        cx        = (BW+1)'(x);
        cy        = (BW+1)'(y);
        out_ready = rdy;
        ovf_clr   = clr;
        vh[k]     = iv && !r;
        cxh[k]    = x;
        cyh[k]    = y;
        if (r) begin
            mq.delete();
            m_ovf    = 1'b0;
            last_rst = k;
        end else begin
            // Sample at step t: tap at t+8, compensated at t+9, pushed on the
            // edge that ends step t+9.
            pop  = (mq.size() != 0) && rdy;
            push = (k >= IT + 1) && (k - IT - 1 > last_rst) && vh[k-IT-1];
            drop = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() == DEPTH) begin
                    drop = 1'b1;
                end else begin
                    e.x = scale(cxh[k-1]);
                    e.y = scale(cyh[k-1]);
                    mq.push_back(e);
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        k++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0)
            begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (x_out !== '0 || y_out !== '0)
            begin n_err++; $display("FAIL reset_data: got %0d/%0d want 0/0", x_out, y_out); end
        n_cmp++; if (fifo_count !== '0)
            begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0)
            begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_basic();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, rnd(), rnd(), 0, 0, 0);
        for (int i = 1; i <= 11; i++) begin
            n_cmp++; if (out_valid !== 1'(i == 10))
                begin n_err++; $display("FAIL basic_valid@%0d: got %b want %b", i, out_valid, i == 10); end
            if (i == 10) begin
                n_cmp++; if (x_out !== (BW+1)'(EXP_X))
                    begin n_err++; $display("FAIL basic_x: got %0d want %0d", x_out, EXP_X); end
                n_cmp++; if (y_out !== (BW+1)'(EXP_Y))
                    begin n_err++; $display("FAIL basic_y: got %0d want %0d", y_out, EXP_Y); end
            end
            cyc(0, (i == IT) ? 200 : rnd(), (i == IT) ? -200 : rnd(), i >= 10, 0, 0);
        end
    endtask

    task automatic test_overflow();
        int fx[4];
        int fy[4];
        int x, y;
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i <= 22; i++) begin
            if (i == 13 || i == 14) begin
                n_cmp++; if (fifo_count !== CW'(DEPTH))
                    begin n_err++; $display("FAIL ovf_count@%0d: got %0d want %0d", i, fifo_count, DEPTH); end
            end
            if (i == 13 || i == 14 || i == 16 || i == 17) begin
                n_cmp++; if (overflow !== 1'(i == 14 || i == 16))
                    begin n_err++; $display("FAIL ovf_flag@%0d: got %b want %b", i, overflow, i == 14 || i == 16); end
            end
            if (i >= 17 && i <= 20) begin
                n_cmp++; if (out_valid !== 1'b1 || x_out !== (BW+1)'(scale(fx[i-17]))
                             || y_out !== (BW+1)'(scale(fy[i-17])))
                    begin n_err++; $display("FAIL ovf_order@%0d: got %b %0d/%0d want 1 %0d/%0d", i,
                        out_valid, x_out, y_out, scale(fx[i-17]), scale(fy[i-17])); end
            end
            if (i == 21) begin
                n_cmp++; if (out_valid !== 1'b0)
                    begin n_err++; $display("FAIL ovf_drained: got %b want 0", out_valid); end
            end
            x = rnd();
            y = rnd();
            if (i >= 8 && i <= 11) begin fx[i-8] = x; fy[i-8] = y; end
            cyc(i <= 4 || i == 6, x, y, i >= 17, i == 15 || i == 16, 0);
        end
    endtask

    task automatic test_full_push_pop();
        int xs[5];
        int x;
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i <= 19; i++) begin
            if (i == 14) begin
                n_cmp++; if (fifo_count !== CW'(DEPTH))
                    begin n_err++; $display("FAIL fpp_count: got %0d want %0d", fifo_count, DEPTH); end
                n_cmp++; if (overflow !== 1'b0)
                    begin n_err++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
            end
            if (i >= 13 && i <= 17) begin
                n_cmp++; if (out_valid !== 1'b1 || x_out !== (BW+1)'(scale(xs[i-13])))
                    begin n_err++; $display("FAIL fpp_head@%0d: got %b %0d want 1 %0d", i,
                        out_valid, x_out, scale(xs[i-13])); end
            end
            if (i == 18) begin
                n_cmp++; if (out_valid !== 1'b0 || fifo_count !== '0)
                    begin n_err++; $display("FAIL fpp_empty: got %b/%0d want 0/0", out_valid, fifo_count); end
            end
            x = rnd();
            if (i >= 8 && i <= 12) xs[i-8] = x;
            cyc(i <= 4, x, rnd(), i >= 13, 0, 0);
        end
    endtask

    task automatic test_reset_midflight();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i <= 19; i++) begin
            if (i > 0) begin
                n_cmp++; if (out_valid !== 1'b0 || fifo_count !== '0)
                    begin n_err++; $display("FAIL midrst@%0d: got %b/%0d want 0/0", i, out_valid, fifo_count); end
            end
            cyc(i == 0, rnd(), rnd(), 1, 0, i == 5);
        end
    endtask

    task automatic test_random(input int n);
        bit exp_v;
        for (int i = 0; i < n; i++) begin
            exp_v = (mq.size() != 0);
            n_cmp++; if (out_valid !== exp_v)
                begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", k, out_valid, exp_v); end
            n_cmp++; if (fifo_count !== CW'(mq.size()))
                begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", k, fifo_count, mq.size()); end
            n_cmp++; if (overflow !== m_ovf)
                begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", k, overflow, m_ovf); end
            if (exp_v) begin
                n_cmp++; if (x_out !== (BW+1)'(mq[0].x) || y_out !== (BW+1)'(mq[0].y))
                    begin n_err++; $display("FAIL rnd_data@%0d: got %0d/%0d want %0d/%0d", k,
                        x_out, y_out, mq[0].x, mq[0].y); end
            end
            cyc($urandom_range(0, 9) < 7, rnd(), rnd(), $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        cx        = '0;
        cy        = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_reset_midflight();
        test_random(800);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_out_stage.md
CORDIC_OUT_STAGE -- requirements
Module: cordic_out_stage

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: CORDIC input vector width; result width is BIT_WIDTH+1.
REQ-002 SHALL have parameter ITERATIONS, default 8: CORDIC pipeline latency in cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: a new Xin/Yin/angle is presented to the upstream CORDIC this cycle.
REQ-007 SHALL have ports cx and cy, input, signed BIT_WIDTH+1 bits each: the CORDIC Xout/Yout.
REQ-008 SHALL have ports x_out and y_out, output, signed BIT_WIDTH+1 bits each: the FIFO head result.
REQ-009 SHALL have port out_valid, input out_ready, 1 bit each: output valid/ready handshake.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag set on a dropped result; port ovf_clr, input, 1 bit, clears it.

Function
REQ-012 SHALL delay in_valid through an ITERATIONS-deep shift register; the tap asserting SHALL mark the cycle in which cx/cy hold the matching result.
REQ-013 SHALL register the captured cx/cy with gain compensation (REQ-024) in the cycle after the tap.
REQ-014 SHALL push the compensated pair into the FIFO on the following edge.
REQ-015 SHALL, for in_valid in cycle t with the FIFO empty, assert out_valid first in cycle t+ITERATIONS+2.
REQ-016 SHALL accept back-to-back in_valid every cycle, giving throughput of 1 result per cycle.
REQ-017 SHALL present the FIFO head combinationally on x_out/y_out while out_valid=1 (show-ahead), and pop on out_valid and out_ready.
REQ-018 SHALL hold out_valid=0 when empty and ignore out_ready when empty.
REQ-019 SHALL, on a push when full and no pop that cycle, drop the new result, set overflow, and leave the FIFO contents unchanged.
REQ-020 SHALL, on a simultaneous push and pop when full, perform both with no overflow and leave fifo_count unchanged.
REQ-021 SHALL, on a simultaneous push and pop when not empty, leave fifo_count unchanged.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-023 SHALL give set priority over ovf_clr when both occur in the same cycle.
REQ-024 SHALL compute compensation as result = (c * 19898 + 16384) >>> 15 (K=0.60725 in Q15, round half up), held at full precision internally and truncated to BIT_WIDTH+1 bits with no saturation needed.

Reset
REQ-025 SHALL, while rst=1, asynchronously clear the valid shift register, compensation register, FIFO pointers, fifo_count, and overflow.
REQ-026 SHALL force out_valid=0 and x_out=y_out=0 during reset.
REQ-027 SHALL discard results in flight on reset mid-operation; no stale push SHALL occur after rst deasserts.

Configuration
REQ-028 SHALL, with macro CORDIC_GAIN_COMP_EN defined, apply REQ-024 scaling.
REQ-029 SHALL, with CORDIC_GAIN_COMP_EN undefined, pass cx/cy through the compensation register unscaled, with latency identical to REQ-015.

Structure
REQ-030 SHALL place the K_Q15 (19898) and ROUND_Q15 (16384) constants, and a result-pair struct typedef {x,y}, in package cordic_pkg.
REQ-031 SHALL implement the buffer as sub-module cordic_res_fifo (parameterised width/depth, valid/ready read, push/full write).

Verification (BIT_WIDTH=8, ITERATIONS=8, FIFO_DEPTH=4, gain comp enabled)
REQ-032 SHALL cover: in_valid pulse at cycle 0 with cx=200, cy=-200 at cycle 8 -> out_valid at cycle 10 with x_out=121, y_out=-121.
REQ-033 SHALL cover: 4 consecutive in_valid with out_ready=0 -> fifo_count=4, overflow=0; 5th pulse -> overflow=1, fifo_count stays 4, first 4 results preserved in order.
REQ-034 SHALL cover: FIFO full, out_ready=1, and a push in the same cycle -> fifo_count stays 4, overflow stays 0, head advances.
REQ-035 SHALL cover: rst asserted at cycle 5 after in_valid at cycle 0 -> no out_valid ever for that sample, fifo_count=0.
REQ-036 SHALL cover: overflow=1 with ovf_clr=1 and a simultaneous overflowing push -> overflow remains 1; ovf_clr alone next cycle -> 0.
REQ-037 SHALL cover: build without CORDIC_GAIN_COMP_EN, cx=200 -> x_out=200 at cycle 10.
